// File: rtl/uart_tx_engine.sv
// ---------------------------------------------------------------------------
// uart_tx_engine
//
// Parametrised UART transmitter. Pulls words from a TX FIFO and serialises
// them onto txd as start bit, 5..DATA_W data bits (LSB first), an optional
// parity bit, and one or two stop bits. It can also drive a break condition.
// Bit timing comes from an external oversampled enable (baud_tick). Each bit
// lasts exactly OVS ticks.
//
// Handshake: a word transfers on every PCLK edge where tx_valid && tx_ready.
// The engine raises tx_ready only while idle, enabled and not breaking, and it
// never depends on tx_valid to do so. The producer keeps tx_valid and tx_data
// stable until the transfer happens. A transferred word is always consumed,
// including one that is rejected for an illegal configuration.
//
// Ports:
//   PCLK, PRESET      system clock, asynchronous active-high reset
//   baud_tick         one-cycle enable at OVS x baud rate
//   tx_en             allows new words to be accepted (sampled in IDLE)
//   cfg_data_bits     data length 5..DATA_W
//   cfg_parity        0 none, 1 even, 2 odd, 3 mark, 4 space, 5..7 illegal
//   cfg_stop2         0 = one stop bit, 1 = two stop bits
//   cfg_break         request a break (line held low)
//   tx_valid/tx_data  FIFO side of the handshake
//   tx_ready          engine takes tx_data this cycle
//   txd               serial output, idle high
//   busy              engine is not idle
//   bit_index         data bit currently on the line (0 outside DATA)
//   done_tx           one-cycle pulse after the last stop bit
//   cfg_err           one-cycle pulse when a word is rejected for its config
// ---------------------------------------------------------------------------
module uart_tx_engine #(
  parameter int DATA_W = 9,
  parameter int OVS    = 16
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              baud_tick,
  input  logic              tx_en,
  input  logic [3:0]        cfg_data_bits,
  input  logic [2:0]        cfg_parity,
  input  logic              cfg_stop2,
  input  logic              cfg_break,
  input  logic              tx_valid,
  input  logic [DATA_W-1:0] tx_data,
  output logic              tx_ready,
  output logic              txd,
  output logic              busy,
  output logic [3:0]        bit_index,
  output logic              done_tx,
  output logic              cfg_err
);

  localparam int             TW        = (OVS > 2) ? $clog2(OVS) : 1;
  localparam logic [TW-1:0]  TICK_LAST = TW'(OVS - 1);
  localparam logic [3:0]     MAX_BITS  = 4'(DATA_W);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4,
    S_BREAK  = 3'd5
  } state_t;

  state_t              state_q,    state_d;
  logic [TW-1:0]       tick_q,     tick_d;
  logic [DATA_W-1:0]   shift_q,    shift_d;
  logic [3:0]          nbits_q,    nbits_d;
  logic [3:0]          bit_cnt_q,  bit_cnt_d;
  logic                par_en_q,   par_en_d;
  logic                par_bit_q,  par_bit_d;
  logic                stop2_q,    stop2_d;
  logic                stop_cnt_q, stop_cnt_d;
  logic                brk_rel_q,  brk_rel_d;
  logic                done_q,     done_d;
  logic                err_q,      err_d;
  logic                txd_q,      txd_d;

  logic                accept;
  logic                bit_end;
  logic [TW-1:0]       tick_next;
  logic                cfg_legal;
  logic                data_xor;
  logic                acc_par_bit;

  // Incoming-word decode, used only on the accept cycle.
  // The parity covers only the configured number of data bits, so the unused
  // upper bits of tx_data are masked out.
  always_comb begin
    data_xor = 1'b0;
    for (int i = 0; i < DATA_W; i++) begin
      if (4'(i) < cfg_data_bits) begin
        data_xor = data_xor ^ tx_data[i];
      end
    end
  end

  always_comb begin
    acc_par_bit = 1'b0;
    case (cfg_parity)
      3'd1:    acc_par_bit = data_xor;
      3'd2:    acc_par_bit = ~data_xor;
      3'd3:    acc_par_bit = 1'b1;
      default: acc_par_bit = 1'b0;
    endcase
  end

  assign cfg_legal = (cfg_data_bits >= 4'd5) && (cfg_data_bits <= MAX_BITS) &&
                     (cfg_parity <= 3'd4);

  // tx_ready is also gated by PRESET so that it reads 0 while reset is held.
  assign tx_ready  = (state_q == S_IDLE) && tx_en && !cfg_break && !PRESET;
  assign accept    = tx_valid && tx_ready;
  assign bit_end   = baud_tick && (tick_q == TICK_LAST);
  assign tick_next = bit_end ? '0 : tick_q + TW'(1);

  // Next-state and datapath.
  always_comb begin
    state_d    = state_q;
    tick_d     = tick_q;
    shift_d    = shift_q;
    nbits_d    = nbits_q;
    bit_cnt_d  = bit_cnt_q;
    par_en_d   = par_en_q;
    par_bit_d  = par_bit_q;
    stop2_d    = stop2_q;
    stop_cnt_d = stop_cnt_q;
    brk_rel_d  = brk_rel_q;
    done_d     = 1'b0;
    err_d      = 1'b0;

    case (state_q)
      S_IDLE: begin
        tick_d    = '0;
        brk_rel_d = 1'b0;
        if (cfg_break) begin
          state_d = S_BREAK;
        end else if (accept) begin
          shift_d    = tx_data;
          nbits_d    = cfg_data_bits;
          par_en_d   = (cfg_parity != 3'd0);
          par_bit_d  = acc_par_bit;
          stop2_d    = cfg_stop2;
          bit_cnt_d  = 4'd0;
          stop_cnt_d = 1'b0;
          if (cfg_legal) begin
            state_d = S_START;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      S_START: begin
        if (baud_tick) tick_d = tick_next;
        if (bit_end)   state_d = S_DATA;
      end

      S_DATA: begin
        if (baud_tick) tick_d = tick_next;
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (bit_cnt_q == nbits_q - 4'd1) begin
            bit_cnt_d = 4'd0;
            state_d   = par_en_q ? S_PARITY : S_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
      end

      S_PARITY: begin
        if (baud_tick) tick_d = tick_next;
        if (bit_end)   state_d = S_STOP;
      end

      S_STOP: begin
        if (baud_tick) tick_d = tick_next;
        if (bit_end) begin
          if (stop2_q && !stop_cnt_q) begin
            stop_cnt_d = 1'b1;
          end else begin
            stop_cnt_d = 1'b0;
            state_d    = S_IDLE;
            done_d     = 1'b1;
          end
        end
      end

      S_BREAK: begin
        // The release period is timed from the first cycle cfg_break is seen
        // low. Until then the tick counter is held at zero.
        if (!brk_rel_q) begin
          tick_d = '0;
          if (!cfg_break) brk_rel_d = 1'b1;
        end else begin
          if (baud_tick) tick_d = tick_next;
          if (bit_end) begin
            state_d   = S_IDLE;
            brk_rel_d = 1'b0;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
        tick_d  = '0;
      end
    endcase
  end

  // txd is registered from the next-state values so that it changes on the
  // same edge as the state and carries no decode glitches.
  always_comb begin
    txd_d = 1'b1;
    case (state_d)
      S_IDLE:   txd_d = 1'b1;
      S_START:  txd_d = 1'b0;
      S_DATA:   txd_d = shift_d[0];
      S_PARITY: txd_d = par_bit_d;
      S_STOP:   txd_d = 1'b1;
      S_BREAK:  txd_d = brk_rel_d;
      default:  txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q    <= S_IDLE;
      tick_q     <= '0;
      shift_q    <= '0;
      nbits_q    <= 4'd0;
      bit_cnt_q  <= 4'd0;
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
      stop2_q    <= 1'b0;
      stop_cnt_q <= 1'b0;
      brk_rel_q  <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      txd_q      <= 1'b1;
    end else begin
      state_q    <= state_d;
      tick_q     <= tick_d;
      shift_q    <= shift_d;
      nbits_q    <= nbits_d;
      bit_cnt_q  <= bit_cnt_d;
      par_en_q   <= par_en_d;
      par_bit_q  <= par_bit_d;
      stop2_q    <= stop2_d;
      stop_cnt_q <= stop_cnt_d;
      brk_rel_q  <= brk_rel_d;
      done_q     <= done_d;
      err_q      <= err_d;
      txd_q      <= txd_d;
    end
  end

  assign txd       = txd_q;
  assign busy      = (state_q != S_IDLE);
  assign bit_index = (state_q == S_DATA) ? bit_cnt_q : 4'd0;
  assign done_tx   = done_q;
  assign cfg_err   = err_q;

endmodule

// File: tb/tb_uart_tx_engine.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_engine
//
// Directed bench for uart_tx_engine (DATA_W=9, OVS=16). A table of frame
// records holds the configuration, the data word and the hand-computed
// txd bit sequence (bit i = i-th bit on the line). Hand-written sequences
// cover back-to-back frames, tick pausing, asynchronous reset and break.
// ---------------------------------------------------------------------------
module tb_uart_tx_engine;

  localparam int DATA_W = 9;
  localparam int OVS    = 16;

  // ---------------- clock / reset ----------------
  logic              PCLK = 1'b0;
  logic              PRESET = 1'b1;
  logic              baud_tick = 1'b0;
  logic              tx_en = 1'b0;
  logic [3:0]        cfg_data_bits = 4'd8;
  logic [2:0]        cfg_parity = 3'd0;
  logic              cfg_stop2 = 1'b0;
  logic              cfg_break = 1'b0;
  logic              tx_valid = 1'b0;
  logic [DATA_W-1:0] tx_data = '0;
  logic              tx_ready;
  logic              txd;
  logic              busy;
  logic [3:0]        bit_index;
  logic              done_tx;
  logic              cfg_err;

  always #5 PCLK = ~PCLK;

  uart_tx_engine #(.DATA_W(DATA_W), .OVS(OVS)) dut (
    .PCLK          (PCLK),
    .PRESET        (PRESET),
    .baud_tick     (baud_tick),
    .tx_en         (tx_en),
    .cfg_data_bits (cfg_data_bits),
    .cfg_parity    (cfg_parity),
    .cfg_stop2     (cfg_stop2),
    .cfg_break     (cfg_break),
    .tx_valid      (tx_valid),
    .tx_data       (tx_data),
    .tx_ready      (tx_ready),
    .txd           (txd),
    .busy          (busy),
    .bit_index     (bit_index),
    .done_tx       (done_tx),
    .cfg_err       (cfg_err)
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0]  nbits;
    logic [2:0]  par;
    logic        stop2;
    logic [8:0]  data;
    logic        exp_err;
    logic [15:0] exp_bits;
    int          len;
  } vec_t;

  vec_t vecs[10];

  // ---------------- driver tasks ----------------
  // Called with the word presented and about to be accepted on the next edge.
  // Walks cycles 1..len*OVS+1 after the accept edge. It checks txd and
  // bit_index at the first and last cycle of every bit, and it checks that
  // done_tx arrives exactly one cycle after the last bit. At cycle 20 the
  // config inputs are changed to show that the frame in flight ignores them.
  task automatic run_frame(input string tag, input logic [15:0] exp_bits,
                           input int len, input int nbits,
                           input logic [2:0] scr_par, input logic [3:0] scr_bits,
                           input logic scr_stop2, input logic drop_valid,
                           input logic [8:0] new_data);
    int   last;
    int   done_at;
    int   bit_no;
    int   exp_idx;
    logic err_seen;
    logic rdy_seen;
    logic busy_gap;
    last = len * OVS;
    done_at = 0;
    err_seen = 1'b0;
    rdy_seen = 1'b0;
    busy_gap = 1'b0;
    for (int k = 1; k <= last + 1; k++) begin
      @(negedge PCLK);
      if (k == 1) begin
        tx_data = new_data;
        if (drop_valid) tx_valid = 1'b0;
      end
      if (k == 20) begin
        cfg_parity    = scr_par;
        cfg_data_bits = scr_bits;
        cfg_stop2     = scr_stop2;
      end
      if (done_tx && done_at == 0) done_at = k;
      if (cfg_err) err_seen = 1'b1;
      if (k <= last) begin
        if (tx_ready) rdy_seen = 1'b1;
        if (!busy) busy_gap = 1'b1;
        if ((k % OVS) == 1 || (k % OVS) == 0) begin
          bit_no  = (k - 1) / OVS;
          exp_idx = (bit_no >= 1 && bit_no <= nbits) ? bit_no - 1 : 0;
          chk($sformatf("%s txd bit%0d cyc%0d", tag, bit_no, k), 32'(txd), 32'(exp_bits[bit_no]));
          chk($sformatf("%s bit_index cyc%0d", tag, k), 32'(bit_index), 32'(exp_idx));
        end
      end
    end
    chk({tag, " done_cycle"}, 32'(done_at), 32'(last + 1));
    chk({tag, " no_cfg_err"}, 32'(err_seen), 32'd0);
    chk({tag, " ready_low_in_frame"}, 32'(rdy_seen), 32'd0);
    chk({tag, " busy_in_frame"}, 32'(busy_gap), 32'd0);
    chk({tag, " ready_at_done"}, 32'(tx_ready), 32'd1);
    chk({tag, " idle_at_done"}, 32'(busy), 32'd0);
  endtask

  task automatic present(input logic [3:0] nb, input logic [2:0] par,
                         input logic st2, input logic [8:0] data);
    cfg_data_bits = nb;
    cfg_parity    = par;
    cfg_stop2     = st2;
    tx_data       = data;
    tx_en         = 1'b1;
    baud_tick     = 1'b1;
    tx_valid      = 1'b1;
  endtask

  // ---------------- test body ----------------
  initial begin : main
    int done_at;
    int hold_err;
    int lo_err;
    int hi_err;

    vecs[0] = '{4'd8, 3'd0, 1'b0, 9'h05A, 1'b0, 16'h02B4, 10};
    vecs[1] = '{4'd7, 3'd1, 1'b1, 9'h013, 1'b0, 16'h0726, 11};
    vecs[2] = '{4'd5, 3'd2, 1'b0, 9'h01F, 1'b0, 16'h00BE, 8};
    vecs[3] = '{4'd5, 3'd3, 1'b0, 9'h01F, 1'b0, 16'h00FE, 8};
    vecs[4] = '{4'd5, 3'd4, 1'b0, 9'h01F, 1'b0, 16'h00BE, 8};
    vecs[5] = '{4'd5, 3'd1, 1'b0, 9'h0E0, 1'b0, 16'h0080, 8};
    vecs[6] = '{4'd9, 3'd2, 1'b1, 9'h1A5, 1'b0, 16'h1B4A, 13};
    vecs[7] = '{4'd4, 3'd0, 1'b0, 9'h055, 1'b1, 16'h0000, 0};
    vecs[8] = '{4'd10, 3'd0, 1'b0, 9'h055, 1'b1, 16'h0000, 0};
    vecs[9] = '{4'd8, 3'd6, 1'b0, 9'h055, 1'b1, 16'h0000, 0};

    // Reset values, with tx_en high to show that tx_ready stays low in reset.
    tx_en = 1'b1;
    repeat (2) @(negedge PCLK);
    chk("rst txd", 32'(txd), 32'd1);
    chk("rst tx_ready", 32'(tx_ready), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst bit_index", 32'(bit_index), 32'd0);
    chk("rst done_tx", 32'(done_tx), 32'd0);
    chk("rst cfg_err", 32'(cfg_err), 32'd0);
    PRESET = 1'b0;
    @(negedge PCLK);
    chk("post_rst tx_ready", 32'(tx_ready), 32'd1);

    // tx_en low blocks acceptance.
    tx_en = 1'b0;
    tx_valid = 1'b1;
    #1 chk("en_low tx_ready", 32'(tx_ready), 32'd0);
    repeat (3) @(negedge PCLK);
    chk("en_low busy", 32'(busy), 32'd0);
    chk("en_low txd", 32'(txd), 32'd1);
    tx_valid = 1'b0;

    // Table-driven frames and config-error words.
    for (int i = 0; i < 10; i++) begin
      @(negedge PCLK);
      present(vecs[i].nbits, vecs[i].par, vecs[i].stop2, vecs[i].data);
      #1 chk($sformatf("v%0d ready_before", i), 32'(tx_ready), 32'd1);
      if (vecs[i].exp_err) begin
        @(negedge PCLK);
        chk($sformatf("v%0d cfg_err_pulse", i), 32'(cfg_err), 32'd1);
        chk($sformatf("v%0d err_txd", i), 32'(txd), 32'd1);
        chk($sformatf("v%0d err_busy", i), 32'(busy), 32'd0);
        chk($sformatf("v%0d err_ready", i), 32'(tx_ready), 32'd1);
        tx_valid = 1'b0;
        @(negedge PCLK);
        chk($sformatf("v%0d cfg_err_one_cycle", i), 32'(cfg_err), 32'd0);
        chk($sformatf("v%0d err_txd2", i), 32'(txd), 32'd1);
      end else begin
        run_frame($sformatf("v%0d", i), vecs[i].exp_bits, vecs[i].len,
                  int'(vecs[i].nbits), 3'd7, 4'd2, ~vecs[i].stop2, 1'b1,
                  ~vecs[i].data);
      end
    end

    // Back-to-back: tx_valid stays high and the second word is waiting.
    // Parity switches to even during frame A, so frame A is still sent
    // without parity and frame B is sent with even parity.
    @(negedge PCLK);
    present(4'd8, 3'd0, 1'b0, 9'h05A);
    run_frame("b2b_a", 16'h02B4, 10, 8, 3'd1, 4'd8, 1'b0, 1'b0, 9'h0A5);
    run_frame("b2b_b", 16'h054A, 11, 8, 3'd1, 4'd8, 1'b0, 1'b1, 9'h0A5);

    // No baud_tick: state and txd hold. Pause at data bit 2 (txd=0).
    @(negedge PCLK);
    present(4'd8, 3'd0, 1'b0, 9'h05A);
    hold_err = 0;
    done_at  = 0;
    for (int k = 1; k <= 56; k++) begin
      @(negedge PCLK);
      if (k == 1) tx_valid = 1'b0;
    end
    chk("pause txd", 32'(txd), 32'd0);
    chk("pause bit_index", 32'(bit_index), 32'd2);
    baud_tick = 1'b0;
    for (int k = 57; k <= 106; k++) begin
      @(negedge PCLK);
      if (txd !== 1'b0 || bit_index !== 4'd2 || busy !== 1'b1) hold_err++;
    end
    baud_tick = 1'b1;
    chk("pause hold", 32'(hold_err), 32'd0);
    for (int k = 107; k <= 260; k++) begin
      @(negedge PCLK);
      if (done_tx && done_at == 0) done_at = k;
    end
    chk("pause done_cycle", 32'(done_at), 32'd211);

    // Asynchronous reset during data bit 3 (0x50 bit 3 = 0).
    @(negedge PCLK);
    present(4'd8, 3'd0, 1'b0, 9'h050);
    for (int k = 1; k <= 70; k++) begin
      @(negedge PCLK);
      if (k == 1) tx_valid = 1'b0;
    end
    chk("pre_rst bit_index", 32'(bit_index), 32'd3);
    chk("pre_rst txd", 32'(txd), 32'd0);
    #2 PRESET = 1'b1;
    #1;
    chk("async_rst txd", 32'(txd), 32'd1);
    chk("async_rst busy", 32'(busy), 32'd0);
    chk("async_rst bit_index", 32'(bit_index), 32'd0);
    chk("async_rst tx_ready", 32'(tx_ready), 32'd0);
    @(negedge PCLK);
    PRESET = 1'b0;
    @(negedge PCLK);
    chk("after_rst busy", 32'(busy), 32'd0);
    chk("after_rst txd", 32'(txd), 32'd1);
    chk("after_rst tx_ready", 32'(tx_ready), 32'd1);

    // Break for 40 cycles, with a word pending that must not be taken.
    tx_valid  = 1'b1;
    cfg_break = 1'b1;
    #1 chk("brk ready_blocked", 32'(tx_ready), 32'd0);
    lo_err = 0;
    hi_err = 0;
    for (int j = 1; j <= 57; j++) begin
      @(negedge PCLK);
      if (j <= 40) begin
        if (txd !== 1'b0 || busy !== 1'b1) lo_err++;
      end else if (j <= 56) begin
        if (txd !== 1'b1 || busy !== 1'b1 || tx_ready !== 1'b0) hi_err++;
      end else begin
        chk("brk end busy", 32'(busy), 32'd0);
        chk("brk end tx_ready", 32'(tx_ready), 32'd1);
        chk("brk end txd", 32'(txd), 32'd1);
      end
      if (j == 40) cfg_break = 1'b0;
      if (j == 56) tx_valid = 1'b0;
    end
    chk("brk low_40", 32'(lo_err), 32'd0);
    chk("brk high_16", 32'(hi_err), 32'd0);

    repeat (2) @(negedge PCLK);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/uart_tx_engine.md
Name: uart_tx_engine

Overview:
- Parametrised UART transmit engine; successor to the fixed 5–8-bit TX FSM.
- Runs on one system clock and paces bits from an external oversampled baud_tick enable.
- Takes bytes from the TX FIFO over a valid/ready handshake and serialises them onto txd.
- Supports runtime data length, five parity modes, 1/2 stop bits and break generation, with explicit config-error and done reporting.

Parameters:
- DATA_W, 9: maximum data bits per frame; legal lengths are 5..DATA_W.
- OVS, 16: baud_tick pulses per bit period; must be at least 2.

Ports:
- PCLK  in  1  system clock.
- PRESET  in  1  asynchronous, active-high reset.
- baud_tick  in  1  one-PCLK enable pulse at OVS×baud rate.
- tx_en  in  1  transmitter enable; sampled only in IDLE.
- cfg_data_bits  in  4  data length, 5..DATA_W.
- cfg_parity  in  3  parity mode: 0 none, 1 even, 2 odd, 3 mark(1), 4 space(0); 5–7 illegal.
- cfg_stop2  in  1  0 = one stop bit, 1 = two stop bits.
- cfg_break  in  1  request a break condition.
- tx_valid  in  1  FIFO word available.
- tx_data  in  DATA_W  frame data, transmitted LSB first.
- tx_ready  out  1  engine accepts tx_data this cycle.
- txd  out  1  serial line, idle high.
- busy  out  1  high in any state other than IDLE.
- bit_index  out  4  index of the data bit being sent; 0 outside DATA.
- done_tx  out  1  one-cycle pulse when the last stop bit ends.
- cfg_err  out  1  one-cycle pulse when a word is rejected for illegal config.

Behaviour:
- Reset values: txd=1, tx_ready=0, busy=0, bit_index=0, done_tx=0, cfg_err=0. State is IDLE and all counters are 0.
- Reset is asynchronous: mid-frame, txd goes to 1 immediately and the partial frame is discarded.
- States: IDLE, START, DATA, PARITY, STOP, BREAK.
- tx_ready is high only when all of these hold: state is IDLE, tx_en=1, cfg_break=0.
- Accept occurs on the cycle where tx_valid && tx_ready. On accept:
  - Latch tx_data, cfg_data_bits, cfg_parity and cfg_stop2. Config changes mid-frame have no effect.
  - If the latched config is legal, go to START. txd falls to 0 on the next PCLK edge, i.e. one cycle after accept.
  - If cfg_data_bits is outside 5..DATA_W, or cfg_parity is 5–7, the word is consumed. cfg_err pulses for 1 cycle on the next edge, the state stays IDLE, and txd stays 1.
- Bit timing: tick_cnt increments on baud_tick. A bit ends on the baud_tick where tick_cnt==OVS-1; tick_cnt then wraps to 0 and the state advances on that same edge. Every bit lasts exactly OVS baud_ticks.
- START: txd=0, then DATA.
- DATA: txd = shift_reg[0], and the register shifts right at each bit end. bit_index counts 0..N-1. After bit N-1, go to PARITY if mode≠0, otherwise STOP.
- PARITY: txd value by mode:
  - even: XOR of the N data bits.
  - odd: the inverse of the even value.
  - mark: 1.
  - space: 0.
  - Then go to STOP.
- STOP: txd=1 for 1 or 2 bit periods per latched cfg_stop2.
  - At the final bit end: done_tx pulses, state goes to IDLE, tick_cnt=0.
  - A new accept may occur in the cycle after done_tx. Back-to-back frames have no idle gap beyond that one cycle.
- BREAK:
  - Entered from IDLE when cfg_break=1. Break has priority over a pending tx_valid.
  - txd=0 while cfg_break stays high.
  - After release, txd=1 for one full bit period (OVS ticks; tick_cnt restarts at release), then IDLE.
  - cfg_break asserted mid-frame is ignored until the frame completes.
- tx_en low mid-frame does not abort the frame; it only blocks the next accept.
- baud_tick held high continuously is legal: each PCLK counts as one tick.
- No baud_tick means state and txd hold indefinitely.

Test Plan:
- OVS=16, 8 data bits, parity none, 1 stop, tx_data=0x5A, continuous baud_tick -> txd pattern 0,0,1,0,1,1,0,1,0,1 with each bit 16 cycles wide; done_tx pulses at cycle 161 after accept; no cfg_err.
- 7 data bits, even parity, 2 stop, tx_data=0x13 -> parity bit 1; frame is 11 bits; done_tx only after the second stop bit; tx_ready=0 throughout.
- Odd parity, 5 data bits, tx_data=0x1F -> parity bit 0. Repeat with mark/space -> parity bits 1/0.
- cfg_data_bits=4, then 10 (DATA_W=9), then cfg_parity=6, each with tx_valid -> cfg_err pulses once per word, txd stays 1, tx_ready handshake completes.
- Two queued words with tx_valid held -> second START begins one cycle after done_tx. Changing cfg_parity mid-frame does not alter the current frame.
- Assert PRESET in DATA bit 3 -> txd=1 and busy=0 asynchronously. After release, cfg_break=1 for 40 cycles -> txd=0 for 40 cycles, then 16 cycles of 1, then tx_ready=1.
